note_block_display_buffer: RTL
==============================

Name: note_block_display_buffer

Overview:
- Successor to the fixed four-slot note output mux.
- Accepts a block of up to MAX_BLOCK notes as a serial valid/ready stream and double-buffers it, so a block being loaded never disturbs the block on display.
- Drives NUM_SLOTS registered note slots; unused slots are blank.
- When a block is longer than the slot count, it can optionally scroll the displayed window through the block at a divided rate.
- Sits between the note detection/quantiser stage and the seven-segment/LCD note renderers.

Parameters:
- NOTE_W, 16, width of one note code.
- NUM_SLOTS, 4, number of display slots driven.
- MAX_BLOCK, 8, maximum notes per block (buffer depth); must be >= NUM_SLOTS.
- LEN_W, $clog2(MAX_BLOCK+1), width of length/count fields.
- SCROLL_DIV, 25000000, clk cycles per scroll step; must be >= 1.
- BLANK, 16'h0000, code driven on empty slots.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-high reset.
- clear, input, 1, synchronous clear of both buffers.
- scroll_en, input, 1, enables window scrolling for long blocks.
- in_valid, input, 1, note beat valid.
- in_ready, output, 1, beat accepted when in_valid && in_ready.
- in_note, input, NOTE_W, note code of the beat.
- in_last, input, 1, final beat of the block.
- note_flat, output, NUM_SLOTS*NOTE_W, slot i occupies bits [i*NOTE_W +: NOTE_W].
- slot_valid, output, NUM_SLOTS, bit i high when slot i shows a real note.
- block_len, output, LEN_W, length of the active block (0..MAX_BLOCK).
- trunc, output, 1, one-cycle pulse when a block was force-committed at MAX_BLOCK.

Behaviour:
- Reset (async, rst=1):
  - Shadow and active buffers are empty; shadow count is 0; active length L is 0.
  - Window offset is 0; scroll tick counter is 0.
  - note_flat drives BLANK in every slot; slot_valid=0; block_len=0; trunc=0.
- in_ready = ~clear (combinational). No other back-pressure exists.
- Load path, on each accepted beat:
  - in_note is written to shadow[cnt] and cnt increments.
  - Commit occurs when in_last=1 or cnt==MAX_BLOCK-1.
  - On commit: the shadow is copied to active, L is set to cnt+1, cnt returns to 0, offset returns to 0, and the tick counter returns to 0.
  - trunc pulses in the cycle after a commit where cnt==MAX_BLOCK-1 and in_last=0.
- After a forced commit, later beats start a new block. There is no drop state.
- Display states, evaluated from L and scroll_en:
  - EMPTY (L==0): all slots BLANK.
  - STATIC (0<L<=NUM_SLOTS, or L>NUM_SLOTS with scroll_en=0): slot i = active[i] for i<min(L,NUM_SLOTS), else BLANK; offset is held at 0.
  - SCROLL (L>NUM_SLOTS and scroll_en=1): slot i = active[(offset+i) mod L].
    - The tick counter counts 0..SCROLL_DIV-1. On wrap, offset <= (offset==L-1) ? 0 : offset+1.
    - Dropping scroll_en returns to STATIC: offset and tick are zeroed on the next edge.
- Latency:
  - Outputs (note_flat, slot_valid, block_len) are registered from active/offset.
  - If the committing beat is accepted at edge T, the new block appears on the outputs after edge T+1.
  - An offset step at edge T appears on the outputs after edge T+1.
- Outputs never show a partially loaded shadow. A block stays displayed until the next commit or clear.
- slot_valid[i] = (i < L) in STATIC and (L>0) in SCROLL. It is registered alongside note_flat.
- clear=1:
  - Shadow cnt, L, offset and tick all go to 0.
  - Any beat presented in that cycle is not accepted (in_ready=0).
  - Outputs are blank after the following edge.
- Commit in the same cycle as a scroll tick: the commit wins and offset=0.
- Reset asserted mid-load or mid-scroll returns everything to reset values immediately, without waiting for a clock edge.
- Width rules:
  - The modulo index is computed on LEN_W+1 bits (offset+i < 2*MAX_BLOCK) with a single conditional subtract of L; no divider.
  - cnt and L never exceed MAX_BLOCK.

Test Plan:
- Reset then idle -> note_flat all 16'h0000, slot_valid=4'b0000, block_len=0.
- Stream 16'h0A01, 16'h0A02 with last on the second beat -> two cycles later slots 0-1 = 0A01/0A02, slots 2-3 = BLANK, slot_valid=4'b0011, block_len=2.
- Load a 3-note block, then stream a 4-note block one beat every 3 cycles -> the 3-note block is held unchanged until the 4th beat commits, then all 4 slots update together.
- SCROLL_DIV=4, scroll_en=1, 6-note block N0..N5 -> window steps every 4 cycles: (N0..N3), (N1..N4), (N2..N5), (N3,N4,N5,N0), (N4,N5,N0,N1), (N5,N0,N1,N2), back to (N0..N3).
- Stream 9 beats with no in_last (MAX_BLOCK=8) -> commit after beat 8, trunc pulses once, block_len=8; beat 9 becomes shadow[0] of the next block.
- clear asserted together with in_valid while scrolling -> beat not accepted, outputs blank next cycle, block_len=0; assert rst mid-stream -> outputs blank without a clock edge.

Source files
------------

// File: rtl/note_block_display_buffer.sv
// Double-buffered note block loader driving NUM_SLOTS registered display slots.
// Outputs lag the active block by one register; scrolling windows through long blocks every SCROLL_DIV cycles.
module note_block_display_buffer #(
  parameter int NOTE_W     = 16,
  parameter int NUM_SLOTS  = 4,
  parameter int MAX_BLOCK  = 8,
  parameter int LEN_W      = $clog2(MAX_BLOCK + 1),
  parameter int SCROLL_DIV = 25000000,
  parameter logic [NOTE_W-1:0] BLANK = {NOTE_W{1'b0}}
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        scroll_en,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NOTE_W-1:0]           in_note,
  input  logic                        in_last,
  output logic [NUM_SLOTS*NOTE_W-1:0] note_flat,
  output logic [NUM_SLOTS-1:0]        slot_valid,
  output logic [LEN_W-1:0]            block_len,
  output logic                        trunc
);

  localparam int IDX_W  = (MAX_BLOCK > 1) ? $clog2(MAX_BLOCK) : 1;
  localparam int IW     = LEN_W + 1;
  localparam int TICK_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(SCROLL_DIV - 1);
  localparam logic [LEN_W-1:0]  LAST_IDX = LEN_W'(MAX_BLOCK - 1);
  localparam logic [LEN_W-1:0]  SLOTS_L  = LEN_W'(NUM_SLOTS);

  logic [NOTE_W-1:0] shadow [MAX_BLOCK];
  logic [NOTE_W-1:0] active [MAX_BLOCK];
  logic [LEN_W-1:0]  cnt;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  offset;
  logic [TICK_W-1:0] tick;

  logic accept, at_cap, commit, scrolling;
  logic [NUM_SLOTS*NOTE_W-1:0] nxt_flat;
  logic [NUM_SLOTS-1:0]        nxt_valid;
  logic [IW-1:0]               idx;

  assign in_ready  = ~clear;
  assign accept    = in_valid & ~clear;
  assign at_cap    = (cnt == LAST_IDX);
  assign commit    = accept & (in_last | at_cap);
  assign scrolling = scroll_en & (len > SLOTS_L);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < MAX_BLOCK; j++) begin
        shadow[j] <= BLANK;
        active[j] <= BLANK;
      end
      cnt    <= '0;
      len    <= '0;
      offset <= '0;
      tick   <= '0;
      trunc  <= 1'b0;
    end else begin
      trunc <= commit & at_cap & ~in_last;
      if (accept) shadow[cnt[IDX_W-1:0]] <= in_note;
      if (clear) begin
        cnt    <= '0;
        len    <= '0;
        offset <= '0;
        tick   <= '0;
      end else if (commit) begin
        // The committing beat is still in flight to the shadow, so splice it in directly.
        for (int j = 0; j < MAX_BLOCK; j++)
          active[j] <= (IDX_W'(j) == cnt[IDX_W-1:0]) ? in_note : shadow[j];
        len    <= cnt + LEN_W'(1);
        cnt    <= '0;
        offset <= '0;
        tick   <= '0;
      end else begin
        if (accept) cnt <= cnt + LEN_W'(1);
        if (scrolling) begin
          if (tick == TICK_MAX) begin
            tick   <= '0;
            offset <= (offset == len - LEN_W'(1)) ? '0 : offset + LEN_W'(1);
          end else begin
            tick <= tick + TICK_W'(1);
          end
        end else begin
          tick   <= '0;
          offset <= '0;
        end
      end
    end
  end

  // offset < len and i < NUM_SLOTS < len while scrolling, so one subtract wraps the index.
  always_comb begin
    nxt_flat  = {NUM_SLOTS{BLANK}};
    nxt_valid = '0;
    idx       = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      idx = {1'b0, offset} + IW'(i);
      if (idx >= {1'b0, len}) idx = idx - {1'b0, len};
      if (scrolling) begin
        nxt_flat[i*NOTE_W +: NOTE_W] = active[idx[IDX_W-1:0]];
        nxt_valid[i]                 = 1'b1;
      end else if (LEN_W'(i) < len) begin
        nxt_flat[i*NOTE_W +: NOTE_W] = active[IDX_W'(i)];
        nxt_valid[i]                 = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      note_flat  <= {NUM_SLOTS{BLANK}};
      slot_valid <= '0;
      block_len  <= '0;
    end else if (clear) begin
      note_flat  <= {NUM_SLOTS{BLANK}};
      slot_valid <= '0;
      block_len  <= '0;
    end else begin
      note_flat  <= nxt_flat;
      slot_valid <= nxt_valid;
      block_len  <= len;
    end
  end

endmodule
